// File: rtl/us_echo_responder.sv
// us_echo_responder: sensor-side model of an HC-SR04-style ultrasonic ranger.
// A trigger of sufficient width starts a burst delay followed by an echo pulse
// whose width encodes distance_cm. A hold-off follows before the next trigger
// can be accepted. Triggers arriving while busy are counted and ignored.
module us_echo_responder #(
  parameter int unsigned TRIG_MIN_CYCLES = 32'd500,
  parameter int unsigned BURST_CYCLES    = 32'd10000,  // must be >= 2
  parameter int unsigned CYCLES_PER_CM   = 32'd2900,
  parameter int unsigned MAX_CM          = 32'd400,
  parameter int unsigned TIMEOUT_CYCLES  = 32'd1900000,
  parameter int unsigned HOLDOFF_CYCLES  = 32'd500000
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic        trigger_in,
  input  logic [8:0]  distance_cm,
  output logic        echo_tx,
  output logic        busy,
  output logic        short_trig_err,
  output logic [7:0]  ignored_trig_cnt,
  output logic [15:0] echo_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG_HIGH = 3'd1,
    S_BURST     = 3'd2,
    S_ECHO      = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  // The burst timer is loaded on the fall cycle itself, so one cycle of the
  // burst delay has already elapsed when BURST is first occupied.
  localparam logic [31:0] BURST_LOAD = BURST_CYCLES - 32'd1;

  // Echo width in clocks; out-of-range or zero distance reports no target.
  function automatic logic [31:0] echo_width(input logic [8:0] d);
    logic [31:0] d_ext;
    logic [31:0] w;
    d_ext = {23'd0, d};
    if ((d_ext == 32'd0) || (d_ext > MAX_CM)) begin
      w = TIMEOUT_CYCLES;
    end else begin
      w = d_ext * CYCLES_PER_CM;
    end
    return w;
  endfunction

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, trig_prev_q;
  logic [31:0] width_q, width_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] echo_w_q, echo_w_d;
  logic        echo_q, echo_d;
  logic        busy_q, busy_d;
  logic        short_q, short_d;
  logic [7:0]  ign_q, ign_d;
  logic [15:0] cnt_q, cnt_d;

  logic trig_s;
  logic trig_rise;
  logic busy_st;

  assign trig_s    = sync2_q;
  assign trig_rise = trig_s & ~trig_prev_q;
  assign busy_st   = (state_q == S_BURST) || (state_q == S_ECHO) ||
                     (state_q == S_HOLDOFF);

  assign echo_tx          = echo_q;
  assign busy             = busy_q;
  assign short_trig_err   = short_q;
  assign ignored_trig_cnt = ign_q;
  assign echo_count       = cnt_q;

  // Bring the asynchronous trigger into the clock domain and keep its last value for edge detection.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      sync1_q     <= trigger_in;
      sync2_q     <= sync1_q;
      trig_prev_q <= sync2_q;
    end
  end

  // Next-state, timer and counter logic for the trigger/burst/echo/hold-off sequence.
  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    timer_d  = timer_q;
    echo_w_d = echo_w_q;
    short_d  = 1'b0;
    ign_d    = ign_q;
    cnt_d    = cnt_q;

    if (busy_st && trig_rise) begin
      ign_d = (ign_q != 8'hFF) ? (ign_q + 8'd1) : ign_q;
    end else begin
      ign_d = ign_q;
    end

    case (state_q)
      S_IDLE: begin
        if (trig_rise) begin
          state_d = S_TRIG_HIGH;
          width_d = 32'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRIG_HIGH: begin
        if (trig_s) begin
          width_d = (width_q < TRIG_MIN_CYCLES) ? (width_q + 32'd1) : width_q;
        end else if (width_q >= TRIG_MIN_CYCLES) begin
          state_d  = S_BURST;
          echo_w_d = echo_width(distance_cm);
          timer_d  = BURST_LOAD;
        end else begin
          short_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        if (timer_q <= 32'd1) begin
          state_d = S_ECHO;
          timer_d = echo_w_q;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      S_ECHO: begin
        if (timer_q <= 32'd1) begin
          state_d = S_HOLDOFF;
          timer_d = HOLDOFF_CYCLES;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      S_HOLDOFF: begin
        if (timer_q <= 32'd1) begin
          state_d = S_IDLE;
          timer_d = 32'd0;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = 32'd0;
      end
    endcase

    echo_d = (state_d == S_ECHO);
    busy_d = (state_d == S_BURST) || (state_d == S_ECHO) || (state_d == S_HOLDOFF);
  end

  // State, timers and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      width_q  <= 32'd0;
      timer_q  <= 32'd0;
      echo_w_q <= 32'd0;
      echo_q   <= 1'b0;
      busy_q   <= 1'b0;
      short_q  <= 1'b0;
      ign_q    <= 8'd0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      timer_q  <= timer_d;
      echo_w_q <= echo_w_d;
      echo_q   <= echo_d;
      busy_q   <= busy_d;
      short_q  <= short_d;
      ign_q    <= ign_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: doc/us_echo_responder.md
Name: us_echo_responder

Overview:
- Emulates the sensor end of the HC-SR04-style ultrasonic protocol: accepts a trigger pulse from the controller and answers with an echo pulse whose width encodes a programmed distance.
- Used for hardware-in-loop and bench closure of the trigger-generator/echo-measurer path, and to inject out-of-range and timeout cases.
- Single clock domain at 50 MHz.

Parameters:
- TRIG_MIN_CYCLES, 500, minimum trigger high width (10 us) for a valid trigger.
- BURST_CYCLES, 10000, delay from trigger fall to echo rise (200 us, 8-cycle 40 kHz burst).
- CYCLES_PER_CM, 2900, echo clocks per cm (58 us/cm).
- MAX_CM, 400, largest in-range distance.
- TIMEOUT_CYCLES, 1900000, echo width for no-target (38 ms).
- HOLDOFF_CYCLES, 500000, dead time after echo fall before a new trigger is accepted (10 ms).

Ports:
- clk_50M  in  1  50 MHz clock.
- reset  in  1  asynchronous, active-high reset.
- trigger_in  in  1  trigger from controller; asynchronous, synchronized internally.
- distance_cm  in  9  target distance; sampled on accepted trigger fall.
- echo_tx  out  1  echo pulse to controller; registered.
- busy  out  1  high in BURST, ECHO, HOLDOFF.
- short_trig_err  out  1  one-cycle pulse when a trigger shorter than TRIG_MIN_CYCLES ends.
- ignored_trig_cnt  out  8  count of trigger rising edges seen while busy; saturates at 255.
- echo_count  out  16  count of completed echoes; wraps.

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, synchronizer flops 0, counters 0. Asserting reset mid-echo drops echo_tx immediately.
- Synchronizer: 2-flop synchronizer on trigger_in gives trig_s. Edges are detected against the previous trig_s value.
- States: IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF.
- IDLE:
  - A trig_s rising edge moves to TRIG_HIGH and clears the width counter.
  - A trigger already high on entry is not accepted; a rising edge is required.
- TRIG_HIGH:
  - The width counter increments each cycle trig_s is high and saturates at TRIG_MIN_CYCLES.
  - On the cycle F where trig_s is first sampled low:
    - If the counted high width is at least TRIG_MIN_CYCLES: latch distance_cm, compute W, go to BURST.
    - Otherwise: pulse short_trig_err for exactly one cycle and return to IDLE.
- Echo width W: 32-bit product distance_cm × CYCLES_PER_CM. If distance_cm is 0 or greater than MAX_CM, W = TIMEOUT_CYCLES.
- Timing from cycle F:
  - echo_tx is high from edge F+BURST_CYCLES through F+BURST_CYCLES+W−1, i.e. exactly W cycles.
  - echo_count increments on the echo_tx falling cycle.
  - HOLDOFF lasts HOLDOFF_CYCLES, then the block returns to IDLE.
- While busy:
  - Each trig_s rising edge increments ignored_trig_cnt (saturating at 255) and has no other effect.
  - distance_cm changes after the latch have no effect on the echo in progress.
- busy is registered from state and asserts the cycle after F.
- Simultaneous events: if the HOLDOFF→IDLE transition coincides with a trig_s rising edge, the edge counts as ignored and is not accepted.

Test Plan:
- Overrides for all scenarios: BURST_CYCLES=100, CYCLES_PER_CM=10, TIMEOUT_CYCLES=5000, HOLDOFF_CYCLES=50, TRIG_MIN_CYCLES=500.
  1. Trigger high 600 cycles, distance_cm=25 -> echo_tx rises 100 cycles after sync'd fall, stays high exactly 250 cycles; echo_count=1; short_trig_err never asserts.
  2. Trigger high 400 cycles -> short_trig_err pulses one cycle at sync'd fall; echo_tx stays 0; busy stays 0.
  3. distance_cm=0, then a separate run with distance_cm=401, each with a valid trigger -> echo_tx high 5000 cycles each time; distance_cm=400 -> 4000 cycles.
  4. Three trigger pulses issued during ECHO/HOLDOFF after a valid trigger -> ignored_trig_cnt=3, only one echo produced; a trigger after HOLDOFF ends produces a second echo; echo_count=2.
  5. Reset asserted mid-ECHO -> echo_tx, busy and all counters go to 0 asynchronously; after release, a valid trigger produces a normal echo.
  6. distance_cm changed from 25 to 40 during BURST -> echo width 250 cycles (latched value).
